board_game_engine: RTL and testbench
====================================

Name: board_game_engine

Overview:
- Parametrised N×N tic-tac-toe style game engine: the next generation of the current 3×3 win checker.
- Accepts moves through a valid/ready handshake and stores the board in registers. Rejects illegal moves, alternates players and enforces a per-turn timeout.
- Detects a win (a full row, column or diagonal through the last move) or a draw.
- Sits between the input/debounce logic and the VGA/LED display logic; the display reads cells through a read port.

Parameters:
- N, 3, board side length (N ≥ 3); a win is N identical marks in a line.
- TURN_TIMEOUT, 0, clock cycles allowed per turn; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- new_game  in  1  synchronous restart, one-cycle pulse
- move_valid  in  1  move request
- move_ready  out  1  engine can accept a move
- move_row  in  $clog2(N)  row of the move
- move_col  in  $clog2(N)  column of the move
- rd_row  in  $clog2(N)  display read row
- rd_col  in  $clog2(N)  display read column
- rd_cell  out  2  combinational cell contents at (rd_row, rd_col)
- current_player  out  1  0 = player 1, 1 = player 2
- move_reject  out  1  one-cycle pulse on an illegal move
- turn_timeout  out  1  one-cycle pulse when a turn is forfeited
- game_over  out  1  game finished
- winner  out  2  00 none, 01 player 1, 10 player 2
- draw  out  1  board full with no winner

Behaviour:
- Cell encoding: 00 empty, 01 player 1, 10 player 2. Empty cells never form a winning line.
- Reset (reset = 0, asynchronous) sets:
  - all cells to 00 and state to WAIT;
  - current_player = 0 and move count = 0;
  - move_reject, turn_timeout, game_over and draw = 0, winner = 00, timeout counter = 0.
- FSM states: WAIT, CHECK, OVER. move_ready = 1 only in WAIT.
- WAIT:
  - A handshake (move_valid & move_ready) at a rising edge, with an in-range row/col and an empty cell:
    - writes the current player's code into that cell;
    - latches row/col as last_row/last_col;
    - increments the move count and goes to CHECK.
  - A handshake with an occupied cell, or row/col ≥ N:
    - board, state and player are unchanged;
    - move_reject = 1 for the following cycle;
    - the timeout counter keeps running.
- CHECK (exactly one cycle, move_ready = 0):
  - Evaluate row last_row, column last_col, the main diagonal if last_row == last_col, and the anti-diagonal if last_row + last_col == N-1.
  - On a win: winner = code of the current player, game_over = 1, go to OVER.
  - Otherwise, if move count == N*N: draw = 1, game_over = 1, go to OVER.
  - Otherwise: toggle current_player, clear the timeout counter, go to WAIT.
- Latency: an accepted move is visible on rd_cell the cycle after the edge. The result (win, draw or player toggle) is visible one cycle later.
- OVER: ignores move_valid; outputs are held until new_game or reset.
- Timeout (TURN_TIMEOUT > 0), counted only in WAIT:
  - when the counter reaches TURN_TIMEOUT-1 with no accepted legal move that cycle: toggle current_player, clear the counter, pulse turn_timeout;
  - a legal move and expiry in the same cycle: the move wins and there is no timeout;
  - an illegal move does not reset the counter.
- new_game has priority over every other event in every state. It clears the board, player, count, counter and result flags, and the FSM goes to WAIT on the next edge.
- Reset asserted mid-CHECK: the partially evaluated result is discarded and everything returns to reset values.
- Counter widths: move count $clog2(N*N+1); timeout counter $clog2(TURN_TIMEOUT+1), minimum 1.

Decomposition:
- Package board_game_pkg holds:
  - cell_t enum (EMPTY, P1, P2);
  - state_t enum (WAIT, CHECK, OVER);
  - winner code constants.
- One sub-module, line_checker: combinational, parametrised by N. Inputs are the flattened board, row/col and the player code; outputs are row/col/diag/anti-diag hit flags.

Test Plan:
- N=3: P1 plays (0,0),(0,1),(0,2), interleaved with P2 at (1,0),(1,1). Required: winner=01, game_over=1 one cycle after the CHECK following move 5, and move_ready=0 afterwards.
- N=4: P2 builds the anti-diagonal (0,3),(1,2),(2,1),(3,0). Required: winner=10 after move 8, draw=0.
- Move onto occupied (1,1), then move at row 3 with N=3. Required: move_reject pulses one cycle each time, with board and current_player unchanged.
- N=3, fill the board with no line (X O X / X O O / O X X order). Required: draw=1, winner=00, game_over=1 after move 9.
- TURN_TIMEOUT=10, no moves. Required: turn_timeout pulses every 10 cycles and current_player toggles. A legal move on the expiry cycle is accepted with no pulse.
- Assert reset during CHECK, then assert new_game in OVER. Required: all outputs go to reset values, move_ready=1 and rd_cell=00 everywhere.

Source files
------------

// File: rtl/board_game_pkg.sv
// Shared types and constants for the N x N board game engine.
package board_game_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Mark written by the player whose turn it is (0 = player 1).
  function automatic cell_t player_code(input logic p);
    return p ? P2 : P1;
  endfunction

endpackage

// File: rtl/line_checker.sv
// Combinational line detector: checks the row, column and (when the
// position lies on them) the two diagonals through one cell.
module line_checker
  import board_game_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2*N*N-1:0]    i_board,
  input  logic [$clog2(N)-1:0] i_row,
  input  logic [$clog2(N)-1:0] i_col,
  input  cell_t               i_code,
  output logic                o_row_hit,
  output logic                o_col_hit,
  output logic                o_diag_hit,
  output logic                o_anti_hit
);

  localparam int unsigned NU = N;

  int unsigned w_r;
  int unsigned w_c;

  assign w_r = 32'(i_row);
  assign w_c = 32'(i_col);

  function automatic logic [1:0] cell_at(input int unsigned r, input int unsigned c);
    return i_board[2*(r*NU+c) +: 2];
  endfunction

  // A line hits only if every cell on it carries the player's mark.
  always_comb begin
    o_row_hit  = 1'b1;
    o_col_hit  = 1'b1;
    o_diag_hit = (w_r == w_c);
    o_anti_hit = (w_r + w_c == NU - 1);
    for (int unsigned k = 0; k < NU; k++) begin
      if (cell_at(w_r, k) != i_code)        o_row_hit  = 1'b0;
      if (cell_at(k, w_c) != i_code)        o_col_hit  = 1'b0;
      if (cell_at(k, k) != i_code)          o_diag_hit = 1'b0;
      if (cell_at(k, NU - 1 - k) != i_code) o_anti_hit = 1'b0;
    end
  end

endmodule

// File: rtl/board_game_engine.sv
// N x N tic-tac-toe engine: move handshake, board storage, turn timeout,
// win/draw detection on the cell of the last move.
module board_game_engine
  import board_game_pkg::*;
#(
  parameter int N            = 3,
  parameter int TURN_TIMEOUT = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 new_game,
  input  logic                 move_valid,
  output logic                 move_ready,
  input  logic [$clog2(N)-1:0] move_row,
  input  logic [$clog2(N)-1:0] move_col,
  input  logic [$clog2(N)-1:0] rd_row,
  input  logic [$clog2(N)-1:0] rd_col,
  output logic [1:0]           rd_cell,
  output logic                 current_player,
  output logic                 move_reject,
  output logic                 turn_timeout,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic                 draw
);

  localparam int unsigned NU    = N;
  localparam int unsigned CELLS = N * N;
  localparam int          IW    = $clog2(N);
  localparam int          CW    = $clog2(N * N + 1);
  localparam int          TW    = (TURN_TIMEOUT < 1) ? 1 : $clog2(TURN_TIMEOUT + 1);
  localparam bit          TO_EN = (TURN_TIMEOUT > 0);
  localparam logic [TW-1:0] TO_LAST = TW'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);

  state_t            r_state;
  state_t            w_next;
  logic [2*N*N-1:0]  r_board;
  logic [IW-1:0]     r_last_row;
  logic [IW-1:0]     r_last_col;
  logic              r_player;
  logic [CW-1:0]     r_count;
  logic [TW-1:0]     r_tcnt;
  logic              r_reject;
  logic              r_timeout;
  logic              r_game_over;
  logic              r_draw;
  logic [1:0]        r_winner;

  logic              w_in_range;
  logic              w_cell_empty;
  logic              w_accept;
  logic              w_reject;
  logic              w_expire;
  logic              w_row_hit, w_col_hit, w_diag_hit, w_anti_hit;
  logic              w_win;
  logic              w_full;
  logic              w_rd_ok;
  int unsigned       w_mv_idx;
  int unsigned       w_rd_idx;
  cell_t             w_code;

  assign w_code       = player_code(r_player);
  assign w_in_range   = (32'(move_row) < NU) && (32'(move_col) < NU);
  assign w_mv_idx     = 2 * (32'(move_row) * NU + 32'(move_col));
  assign w_cell_empty = w_in_range && (r_board[w_mv_idx +: 2] == EMPTY);
  assign w_win        = w_row_hit | w_col_hit | w_diag_hit | w_anti_hit;
  assign w_full       = (r_count == CW'(CELLS));

  assign w_rd_ok  = (32'(rd_row) < NU) && (32'(rd_col) < NU);
  assign w_rd_idx = 2 * (32'(rd_row) * NU + 32'(rd_col));
  assign rd_cell  = w_rd_ok ? r_board[w_rd_idx +: 2] : 2'b00;

  assign move_ready     = (r_state == WAIT);
  assign current_player = r_player;
  assign move_reject    = r_reject;
  assign turn_timeout   = r_timeout;
  assign game_over      = r_game_over;
  assign winner         = r_winner;
  assign draw           = r_draw;

  line_checker #(.N(N)) u_line_checker (
    .i_board    (r_board),
    .i_row      (r_last_row),
    .i_col      (r_last_col),
    .i_code     (w_code),
    .o_row_hit  (w_row_hit),
    .o_col_hit  (w_col_hit),
    .o_diag_hit (w_diag_hit),
    .o_anti_hit (w_anti_hit)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= WAIT;
    else        r_state <= w_next;
  end

  // Next state and per-cycle events; new_game overrides everything.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_expire = 1'b0;
    if (new_game) begin
      w_next = WAIT;
    end else begin
      case (r_state)
        WAIT: begin
          if (move_valid) begin
            if (w_cell_empty) begin
              w_accept = 1'b1;
              w_next   = CHECK;
            end else begin
              w_reject = 1'b1;
            end
          end
          // A legal move on the expiry cycle takes precedence over the timeout.
          if (TO_EN && !w_accept && (r_tcnt == TO_LAST)) w_expire = 1'b1;
        end
        CHECK:   w_next = (w_win || w_full) ? OVER : WAIT;
        OVER:    w_next = OVER;
        default: w_next = WAIT;
      endcase
    end
  end

  // Board, turn bookkeeping and result flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_board     <= '0;
      r_last_row  <= '0;
      r_last_col  <= '0;
      r_player    <= 1'b0;
      r_count     <= '0;
      r_tcnt      <= '0;
      r_reject    <= 1'b0;
      r_timeout   <= 1'b0;
      r_game_over <= 1'b0;
      r_draw      <= 1'b0;
      r_winner    <= WIN_NONE;
    end else if (new_game) begin
      r_board     <= '0;
      r_last_row  <= '0;
      r_last_col  <= '0;
      r_player    <= 1'b0;
      r_count     <= '0;
      r_tcnt      <= '0;
      r_reject    <= 1'b0;
      r_timeout   <= 1'b0;
      r_game_over <= 1'b0;
      r_draw      <= 1'b0;
      r_winner    <= WIN_NONE;
    end else begin
      r_reject  <= w_reject;
      r_timeout <= w_expire;
      case (r_state)
        WAIT: begin
          if (w_accept) begin
            r_board[w_mv_idx +: 2] <= w_code;
            r_last_row             <= move_row;
            r_last_col             <= move_col;
            r_count                <= r_count + CW'(1);
          end else if (w_expire) begin
            r_player <= ~r_player;
            r_tcnt   <= '0;
          end else if (TO_EN) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        CHECK: begin
          if (w_win) begin
            r_winner    <= r_player ? WIN_P2 : WIN_P1;
            r_game_over <= 1'b1;
          end else if (w_full) begin
            r_draw      <= 1'b1;
            r_game_over <= 1'b1;
          end else begin
            r_player <= ~r_player;
            r_tcnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_game_engine.sv
// Directed bench: a 3x3 engine with a 10-cycle turn timeout and a 4x4
// engine with the timeout disabled, driven from hand-computed vectors.
module tb_board_game_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #25 clk = ~clk;

  // 3x3, TURN_TIMEOUT = 10
  logic       ng3, v3, rdy3, pl3, rej3, to3, go3, dr3;
  logic [1:0] r3, c3, rr3, rc3, cell3, win3;
  // 4x4, TURN_TIMEOUT = 0
  logic       ng4, v4, rdy4, pl4, rej4, to4, go4, dr4;
  logic [1:0] r4, c4, rr4, rc4, cell4, win4;

  logic seen_to4 = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  board_game_engine #(.N(3), .TURN_TIMEOUT(10)) dut3 (
    .clock(clk), .reset(rst_n), .new_game(ng3), .move_valid(v3), .move_ready(rdy3),
    .move_row(r3), .move_col(c3), .rd_row(rr3), .rd_col(rc3), .rd_cell(cell3),
    .current_player(pl3), .move_reject(rej3), .turn_timeout(to3),
    .game_over(go3), .winner(win3), .draw(dr3)
  );

  board_game_engine #(.N(4), .TURN_TIMEOUT(0)) dut4 (
    .clock(clk), .reset(rst_n), .new_game(ng4), .move_valid(v4), .move_ready(rdy4),
    .move_row(r4), .move_col(c4), .rd_row(rr4), .rd_col(rc4), .rd_cell(cell4),
    .current_player(pl4), .move_reject(rej4), .turn_timeout(to4),
    .game_over(go4), .winner(win4), .draw(dr4)
  );

  always @(negedge clk) if (to4) seen_to4 = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cell3_is(input string tag, input int r, input int c, input int exp);
    rr3 = 2'(r);
    rc3 = 2'(c);
    #1;
    check_eq(tag, 32'(cell3), exp);
  endtask

  // Handshake only: returns 1 time unit after the accepting edge.
  task automatic try3(input int r, input int c);
    @(negedge clk);
    v3 = 1'b1;
    r3 = 2'(r);
    c3 = 2'(c);
    @(posedge clk);
    #1;
    v3 = 1'b0;
  endtask

  // Full legal move: handshake plus the CHECK cycle.
  task automatic mv3(input int r, input int c);
    try3(r, c);
    @(posedge clk);
    #1;
  endtask

  task automatic newgame3();
    @(negedge clk);
    ng3 = 1'b1;
    @(posedge clk);
    #1;
    ng3 = 1'b0;
  endtask

  task automatic mv4(input int r, input int c);
    @(negedge clk);
    v4 = 1'b1;
    r4 = 2'(r);
    c4 = 2'(c);
    @(posedge clk);
    #1;
    v4 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ng3 = 1'b0; v3 = 1'b0; r3 = '0; c3 = '0; rr3 = '0; rc3 = '0;
    ng4 = 1'b0; v4 = 1'b0; r4 = '0; c4 = '0; rr4 = '0; rc4 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check_eq("rst_ready",  32'(rdy3), 1);
    check_eq("rst_player", 32'(pl3),  0);
    check_eq("rst_winner", 32'(win3), 0);
    check_eq("rst_over",   32'(go3),  0);
    check_eq("rst_draw",   32'(dr3),  0);
    check_eq("rst_reject", 32'(rej3), 0);
    check_eq("rst_tout",   32'(to3),  0);
    cell3_is("rst_cell11", 1, 1, 0);
    check_eq("rst_ready4", 32'(rdy4), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Row 0 win for player 1
    try3(0, 0);
    cell3_is("win_cell00_visible", 0, 0, 1);
    check_eq("win_ready_in_check", 32'(rdy3), 0);
    @(posedge clk);
    #1;
    check_eq("win_toggle_p2", 32'(pl3), 1);
    check_eq("win_not_over",  32'(go3), 0);
    mv3(1, 0);
    mv3(0, 1);
    mv3(1, 1);
    try3(0, 2);
    check_eq("win_over_in_check", 32'(go3), 0);
    @(posedge clk);
    #1;
    check_eq("win_winner",    32'(win3), 1);
    check_eq("win_over",      32'(go3),  1);
    check_eq("win_ready_low", 32'(rdy3), 0);
    check_eq("win_no_draw",   32'(dr3),  0);
    check_eq("win_player",    32'(pl3),  0);

    // OVER ignores move_valid
    try3(2, 2);
    cell3_is("over_cell22", 2, 2, 0);
    check_eq("over_no_reject", 32'(rej3), 0);
    check_eq("over_held",      32'(win3), 1);

    // new_game from OVER clears everything
    newgame3();
    check_eq("ng_ready",  32'(rdy3), 1);
    check_eq("ng_winner", 32'(win3), 0);
    check_eq("ng_over",   32'(go3),  0);
    check_eq("ng_player", 32'(pl3),  0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        cell3_is("ng_cell_clear", r, c, 0);

    // Illegal moves: occupied cell, then out-of-range row
    mv3(1, 1);
    try3(1, 1);
    check_eq("rej_occ_pulse",  32'(rej3), 1);
    check_eq("rej_occ_ready",  32'(rdy3), 1);
    check_eq("rej_occ_player", 32'(pl3),  1);
    cell3_is("rej_occ_cell", 1, 1, 1);
    @(posedge clk);
    #1;
    check_eq("rej_occ_end", 32'(rej3), 0);
    try3(3, 0);
    check_eq("rej_oor_pulse",  32'(rej3), 1);
    check_eq("rej_oor_player", 32'(pl3),  1);
    cell3_is("rej_oor_cell10", 1, 0, 0);
    @(posedge clk);
    #1;
    check_eq("rej_oor_end", 32'(rej3), 0);

    // Draw: X O X / X O O / O X X
    newgame3();
    mv3(0, 0); mv3(0, 1); mv3(0, 2); mv3(1, 1);
    mv3(1, 0); mv3(1, 2); mv3(2, 1); mv3(2, 0);
    check_eq("draw_not_over8", 32'(go3), 0);
    check_eq("draw_player8",   32'(pl3), 0);
    mv3(2, 2);
    check_eq("draw_flag",   32'(dr3),  1);
    check_eq("draw_winner", 32'(win3), 0);
    check_eq("draw_over",   32'(go3),  1);
    cell3_is("draw_cell20", 2, 0, 2);
    cell3_is("draw_cell22", 2, 2, 1);

    // Turn timeout: expiry every 10 idle cycles
    newgame3();
    repeat (9) @(posedge clk);
    #1;
    check_eq("to_quiet",        32'(to3), 0);
    check_eq("to_quiet_player", 32'(pl3), 0);
    @(posedge clk);
    #1;
    check_eq("to_first",        32'(to3), 1);
    check_eq("to_first_player", 32'(pl3), 1);
    @(posedge clk);
    #1;
    check_eq("to_first_end", 32'(to3), 0);
    repeat (8) @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("to_second",        32'(to3), 1);
    check_eq("to_second_player", 32'(pl3), 0);
    repeat (9) @(posedge clk);
    #1;
    v3 = 1'b1;
    r3 = 2'd2;
    c3 = 2'd2;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    check_eq("to_move_wins", 32'(to3),  0);
    check_eq("to_move_ready", 32'(rdy3), 0);
    cell3_is("to_move_cell", 2, 2, 1);
    @(posedge clk);
    #1;
    check_eq("to_move_toggle", 32'(pl3), 1);
    check_eq("to_move_no_tout", 32'(to3), 0);

    // Reset asserted while the winning move is in CHECK
    newgame3();
    mv3(0, 0); mv3(1, 0); mv3(0, 1); mv3(1, 1);
    try3(0, 2);
    rst_n = 1'b0;
    #1;
    check_eq("rstchk_winner", 32'(win3), 0);
    check_eq("rstchk_over",   32'(go3),  0);
    check_eq("rstchk_ready",  32'(rdy3), 1);
    check_eq("rstchk_player", 32'(pl3),  0);
    cell3_is("rstchk_cell00", 0, 0, 0);
    cell3_is("rstchk_cell02", 0, 2, 0);
    @(posedge clk);
    #1;
    check_eq("rstchk_held_winner", 32'(win3), 0);
    check_eq("rstchk_held_over",   32'(go3),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // 4x4 with timeout disabled: player 2 takes the anti-diagonal
    check_eq("n4_no_timeout", 32'(seen_to4), 0);
    check_eq("n4_player",     32'(pl4),      0);
    mv4(0, 0); mv4(0, 3); mv4(0, 1); mv4(1, 2);
    mv4(0, 2); mv4(2, 1); mv4(1, 0);
    check_eq("n4_not_over7", 32'(go4),  0);
    check_eq("n4_winner7",   32'(win4), 0);
    mv4(3, 0);
    check_eq("n4_winner", 32'(win4), 2);
    check_eq("n4_over",   32'(go4),  1);
    check_eq("n4_draw",   32'(dr4),  0);
    check_eq("n4_ready",  32'(rdy4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
